// File: rtl/seq_start_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_start_gen
// Purpose  : SBUS-mapped start/trigger generator feeding SEQ_EXT_START of the
//            downstream sequencer. Emits programmable start pulses (delay,
//            width, period, repeat count) launched by a software strobe or,
//            optionally, an external trigger edge. Single clock domain.
// Options  : SEQ_START_GEN_EXT_TRIG_EN - adds the external trigger sync and
//            edge-detect path, CONF bits 0/2 and the MISSED counter.
// Ports    : BUS_CLK      in  clock, rising edge
//            BUS_RST      in  asynchronous active-high reset
//            BUS_ADD      in  byte address [ABUSWIDTH]
//            BUS_DATA_IN  in  write data [8]
//            BUS_DATA_OUT out registered read data [8]
//            BUS_RD       in  read strobe
//            BUS_WR       in  write strobe
//            EXT_TRIGGER  in  asynchronous trigger input
//            START_OUT    out start pulse
//            BUSY         out high while a run is in progress
// Revision : 1.0 - initial release
// ============================================================================
module seq_start_gen #(
    parameter int unsigned              ABUSWIDTH = 16,
    parameter logic [ABUSWIDTH-1:0]     BASEADDR  = '0,
    parameter logic [ABUSWIDTH-1:0]     HIGHADDR  = '0
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    input  logic                 EXT_TRIGGER,
    output logic                 START_OUT,
    output logic                 BUSY
);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_DELAY = 2'd1;
    localparam logic [1:0] C_ST_PULSE = 2'd2;
    localparam logic [1:0] C_ST_GAP   = 2'd3;

    localparam logic [ABUSWIDTH-1:0] C_SPAN     = HIGHADDR - BASEADDR;
    localparam logic [ABUSWIDTH-1:0] C_NUM_REGS = ABUSWIDTH'(12);
    localparam logic [7:0]           C_VERSION  = 8'd1;
`ifdef SEQ_START_GEN_EXT_TRIG_EN
    localparam logic [2:0]           C_CONF_MASK = 3'b111;
`else
    localparam logic [2:0]           C_CONF_MASK = 3'b010;
`endif

    // ---------------- bus decode ----------------
    logic [ABUSWIDTH-1:0] w_offset;
    logic                 w_hit;
    logic [3:0]           w_sel;
    logic                 w_wr, w_rd, w_soft_rst, w_stop, w_sw_start;

    // Modular subtraction makes one unsigned compare cover both bounds.
    assign w_offset   = BUS_ADD - BASEADDR;
    assign w_hit      = (w_offset <= C_SPAN);
    assign w_sel      = (w_offset < C_NUM_REGS) ? w_offset[3:0] : 4'hF;
    assign w_wr       = BUS_WR & w_hit;
    assign w_rd       = BUS_RD & w_hit;
    assign w_soft_rst = w_wr & (w_sel == 4'd0);
    assign w_sw_start = w_wr & (w_sel == 4'd1) & BUS_DATA_IN[0];
    assign w_stop     = w_wr & (w_sel == 4'd1) & BUS_DATA_IN[1];

    // ---------------- registers ----------------
    logic [2:0]  r_conf;
    logic [15:0] r_delay, r_width, r_period, r_repeat;
    logic        r_done;
    logic [1:0]  r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt, r_pcnt, w_pcnt_nxt;
    logic [15:0] r_sh_weff_m1, r_sh_gap_m1, r_sh_repeat;
    logic        r_sh_inv;
    logic        r_busy, r_start_out, w_start_out_nxt;
    logic [7:0]  r_data_out, w_rd_mux;
    logic        w_ext_edge, w_launch, w_run_done;
    logic [7:0]  w_missed;
    logic [15:0] w_weff, w_gap;

    // A START strobe and an ext edge in the same cycle collapse into one launch.
    assign w_launch = (w_sw_start | w_ext_edge) & (r_state == C_ST_IDLE) & ~w_stop;

    // Gap is P_eff - W_eff, computed without a 17-bit W_eff+1 term.
    assign w_weff = (r_width == 16'd0) ? 16'd1 : r_width;
    assign w_gap  = (r_period > w_weff) ? (r_period - w_weff) : 16'd1;

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_conf   <= 3'd0;
            r_delay  <= 16'd0;
            r_width  <= 16'd1;
            r_period <= 16'd0;
            r_repeat <= 16'd1;
        end else if (w_soft_rst) begin
            r_conf   <= 3'd0;
            r_delay  <= 16'd0;
            r_width  <= 16'd1;
            r_period <= 16'd0;
            r_repeat <= 16'd1;
        end else if (w_wr) begin
            case (w_sel)
                4'd2:    r_conf           <= BUS_DATA_IN[2:0] & C_CONF_MASK;
                4'd3:    r_delay[7:0]     <= BUS_DATA_IN;
                4'd4:    r_delay[15:8]    <= BUS_DATA_IN;
                4'd5:    r_width[7:0]     <= BUS_DATA_IN;
                4'd6:    r_width[15:8]    <= BUS_DATA_IN;
                4'd7:    r_period[7:0]    <= BUS_DATA_IN;
                4'd8:    r_period[15:8]   <= BUS_DATA_IN;
                4'd9:    r_repeat[7:0]    <= BUS_DATA_IN;
                4'd10:   r_repeat[15:8]   <= BUS_DATA_IN;
                default: ;
            endcase
        end
    end

    // ---------------- sequencing FSM ----------------
    // Each timed state lasts (counter load + 1) cycles and exits at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pcnt_nxt  = r_pcnt;
        w_run_done  = 1'b0;
        case (r_state)
            C_ST_IDLE: begin
                if (w_launch) begin
                    w_pcnt_nxt = 16'd1;
                    if (r_delay != 16'd0) begin
                        w_state_nxt = C_ST_DELAY;
                        w_cnt_nxt   = r_delay - 16'd1;
                    end else begin
                        w_state_nxt = C_ST_PULSE;
                        w_cnt_nxt   = w_weff - 16'd1;
                    end
                end
            end
            C_ST_DELAY: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = C_ST_PULSE;
                    w_cnt_nxt   = r_sh_weff_m1;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            C_ST_PULSE: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = C_ST_GAP;
                    w_cnt_nxt   = r_sh_gap_m1;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                if (r_cnt != 16'd0) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end else if (r_sh_repeat == 16'd0) begin
                    w_state_nxt = C_ST_PULSE;
                    w_cnt_nxt   = r_sh_weff_m1;
                end else if (r_pcnt < r_sh_repeat) begin
                    w_state_nxt = C_ST_PULSE;
                    w_cnt_nxt   = r_sh_weff_m1;
                    w_pcnt_nxt  = r_pcnt + 16'd1;
                end else begin
                    w_state_nxt = C_ST_IDLE;
                    w_run_done  = 1'b1;
                end
            end
        endcase
        if (w_stop) begin
            w_state_nxt = C_ST_IDLE;
            w_run_done  = 1'b0;
        end
    end

    // START_OUT follows the current state one edge later; STOP and IDLE use
    // the live INVERT bit so the idle level tracks CONF immediately.
    always_comb begin
        w_start_out_nxt = r_conf[1];
        if (!w_stop && r_state != C_ST_IDLE)
            w_start_out_nxt = (r_state == C_ST_PULSE) ? ~r_sh_inv : r_sh_inv;
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_state      <= C_ST_IDLE;
            r_cnt        <= 16'd0;
            r_pcnt       <= 16'd0;
            r_busy       <= 1'b0;
            r_start_out  <= 1'b0;
            r_done       <= 1'b0;
            r_sh_weff_m1 <= 16'd0;
            r_sh_gap_m1  <= 16'd0;
            r_sh_repeat  <= 16'd1;
            r_sh_inv     <= 1'b0;
        end else if (w_soft_rst) begin
            r_state      <= C_ST_IDLE;
            r_cnt        <= 16'd0;
            r_pcnt       <= 16'd0;
            r_busy       <= 1'b0;
            r_start_out  <= 1'b0;
            r_done       <= 1'b0;
            r_sh_weff_m1 <= 16'd0;
            r_sh_gap_m1  <= 16'd0;
            r_sh_repeat  <= 16'd1;
            r_sh_inv     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pcnt      <= w_pcnt_nxt;
            r_busy      <= (w_state_nxt != C_ST_IDLE);
            r_start_out <= w_start_out_nxt;
            if (w_launch) begin
                r_done       <= 1'b0;
                r_sh_weff_m1 <= w_weff - 16'd1;
                r_sh_gap_m1  <= w_gap - 16'd1;
                r_sh_repeat  <= r_repeat;
                r_sh_inv     <= r_conf[1];
            end else if (w_run_done) begin
                r_done <= 1'b1;
            end
        end
    end

    // ---------------- external trigger ----------------
`ifdef SEQ_START_GEN_EXT_TRIG_EN
    logic [2:0] r_ext_sync;
    logic       r_ext_edge;
    logic [7:0] r_missed;
    logic       w_ext_raw;

    // Two sync flops, one history flop, one registered edge: three cycles.
    assign w_ext_raw = r_conf[0] & (r_conf[2] ? (r_ext_sync[2] & ~r_ext_sync[1])
                                              : (~r_ext_sync[2] & r_ext_sync[1]));

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_ext_sync <= 3'd0;
            r_ext_edge <= 1'b0;
            r_missed   <= 8'd0;
        end else if (w_soft_rst) begin
            r_ext_sync <= {r_ext_sync[1:0], EXT_TRIGGER};
            r_ext_edge <= 1'b0;
            r_missed   <= 8'd0;
        end else begin
            r_ext_sync <= {r_ext_sync[1:0], EXT_TRIGGER};
            r_ext_edge <= w_ext_raw;
            if (r_ext_edge && r_state != C_ST_IDLE && r_missed != 8'hFF)
                r_missed <= r_missed + 8'd1;
        end
    end

    assign w_ext_edge = r_ext_edge;
    assign w_missed   = r_missed;
`else
    logic w_unused_ext;
    assign w_unused_ext = EXT_TRIGGER;
    assign w_ext_edge   = 1'b0;
    assign w_missed     = 8'h00;
`endif

    // ---------------- read path ----------------
    always_comb begin
        w_rd_mux = 8'h00;
        case (w_sel)
            4'd0:    w_rd_mux = C_VERSION;
            4'd1:    w_rd_mux = {6'd0, r_done, ~r_busy};
            4'd2:    w_rd_mux = {5'd0, r_conf};
            4'd3:    w_rd_mux = r_delay[7:0];
            4'd4:    w_rd_mux = r_delay[15:8];
            4'd5:    w_rd_mux = r_width[7:0];
            4'd6:    w_rd_mux = r_width[15:8];
            4'd7:    w_rd_mux = r_period[7:0];
            4'd8:    w_rd_mux = r_period[15:8];
            4'd9:    w_rd_mux = r_repeat[7:0];
            4'd10:   w_rd_mux = r_repeat[15:8];
            4'd11:   w_rd_mux = w_missed;
            default: w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST)
            r_data_out <= 8'h00;
        else
            r_data_out <= w_rd ? w_rd_mux : 8'h00;
    end

    assign BUS_DATA_OUT = r_data_out;
    assign START_OUT    = r_start_out;
    assign BUSY         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_start_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_start_gen
// Purpose  : Directed self-checking bench for seq_start_gen. Each scenario
//            task drives the bus and compares outputs against hand-derived
//            cycle-by-cycle expectations. Cycle k is the value seen at the
//            falling edge after rising edge t0+k, where t0 samples the write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_start_gen;

    localparam logic [15:0] C_BASE = 16'h4000;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST = 1'b1;
    logic [15:0] BUS_ADD = 16'h0000;
    logic [7:0]  BUS_DATA_IN = 8'h00;
    logic [7:0]  BUS_DATA_OUT;
    logic        BUS_RD = 1'b0;
    logic        BUS_WR = 1'b0;
    logic        EXT_TRIGGER = 1'b0;
    logic        START_OUT;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    seq_start_gen #(
        .ABUSWIDTH (16),
        .BASEADDR  (16'h4000),
        .HIGHADDR  (16'h400F)
    ) dut (
        .BUS_CLK      (BUS_CLK),
        .BUS_RST      (BUS_RST),
        .BUS_ADD      (BUS_ADD),
        .BUS_DATA_IN  (BUS_DATA_IN),
        .BUS_DATA_OUT (BUS_DATA_OUT),
        .BUS_RD       (BUS_RD),
        .BUS_WR       (BUS_WR),
        .EXT_TRIGGER  (EXT_TRIGGER),
        .START_OUT    (START_OUT),
        .BUSY         (BUSY)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge BUS_CLK);
        BUS_ADD = addr; BUS_DATA_IN = data; BUS_WR = 1'b1;
        @(negedge BUS_CLK);
        BUS_WR = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
        @(negedge BUS_CLK);
        BUS_ADD = addr; BUS_RD = 1'b1;
        @(negedge BUS_CLK);
        BUS_RD = 1'b0;
        data = BUS_DATA_OUT;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        #12;
        total++; if (START_OUT !== 1'b0) begin bad++; $display("FAIL reset_start_out got=%b exp=0", START_OUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        total++; if (BUS_DATA_OUT !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h exp=00", BUS_DATA_OUT); end
        @(negedge BUS_CLK); BUS_RST = 1'b0;
        bus_read(C_BASE + 16'd0, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL version got=%h exp=01", d); end
        bus_read(C_BASE + 16'd1, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL reset_status got=%h exp=01", d); end
        bus_read(C_BASE + 16'd5, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL reset_width got=%h exp=01", d); end
        bus_read(C_BASE + 16'd9, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL reset_repeat got=%h exp=01", d); end
        bus_read(C_BASE + 16'd12, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL unmapped_offset got=%h exp=00", d); end
        bus_read(16'h3FFF, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL out_of_range got=%h exp=00", d); end
    endtask

    task automatic test_async_reset;
        logic [7:0] d;
        bus_write(C_BASE + 16'd5, 8'd100);
        bus_write(C_BASE + 16'd1, 8'h01);
        repeat (3) @(negedge BUS_CLK);
        total++; if (START_OUT !== 1'b1) begin bad++; $display("FAIL pre_rst_pulse got=%b exp=1", START_OUT); end
        #2 BUS_RST = 1'b1;
        #1;
        total++; if (START_OUT !== 1'b0) begin bad++; $display("FAIL async_rst_start_out got=%b exp=0", START_OUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL async_rst_busy got=%b exp=0", BUSY); end
        @(negedge BUS_CLK); BUS_RST = 1'b0;
        bus_read(C_BASE + 16'd5, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL async_rst_width got=%h exp=01", d); end
        bus_read(C_BASE + 16'd9, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL async_rst_repeat got=%h exp=01", d); end
    endtask

    task automatic test_delay_single;
        logic [7:0] d, so_v, busy_v;
        bus_write(C_BASE + 16'd3, 8'd3);
        bus_write(C_BASE + 16'd5, 8'd2);
        bus_write(C_BASE + 16'd1, 8'h01);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge BUS_CLK);
            so_v[k] = START_OUT; busy_v[k] = BUSY;
        end
        total++; if (so_v !== 8'h30) begin bad++; $display("FAIL delay_start_out got=%h exp=30", so_v); end
        total++; if (busy_v !== 8'h3F) begin bad++; $display("FAIL delay_busy got=%h exp=3f", busy_v); end
        bus_read(C_BASE + 16'd1, d);
        total++; if (d !== 8'h03) begin bad++; $display("FAIL delay_status got=%h exp=03", d); end
    endtask

    task automatic test_repeat;
        logic [7:0]  d;
        logic [19:0] so_v, busy_v;
        bus_write(C_BASE + 16'd3, 8'd0);
        bus_write(C_BASE + 16'd7, 8'd5);
        bus_write(C_BASE + 16'd9, 8'd3);
        bus_write(C_BASE + 16'd1, 8'h01);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge BUS_CLK);
            so_v[k] = START_OUT; busy_v[k] = BUSY;
        end
        total++; if (so_v !== 20'h018C6) begin bad++; $display("FAIL repeat_start_out got=%h exp=018c6", so_v); end
        total++; if (busy_v !== 20'h07FFF) begin bad++; $display("FAIL repeat_busy got=%h exp=07fff", busy_v); end
        bus_read(C_BASE + 16'd1, d);
        total++; if (d !== 8'h03) begin bad++; $display("FAIL repeat_status got=%h exp=03", d); end
    endtask

    task automatic test_continuous_stop;
        logic [7:0]  d;
        logic [11:0] so_v, busy_v;
        bus_write(C_BASE + 16'd5, 8'd1);
        bus_write(C_BASE + 16'd7, 8'd1);
        bus_write(C_BASE + 16'd9, 8'd0);
        bus_write(C_BASE + 16'd1, 8'h01);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge BUS_CLK);
            so_v[k] = START_OUT; busy_v[k] = BUSY;
        end
        total++; if (so_v !== 12'hAAA) begin bad++; $display("FAIL clamp_toggle got=%h exp=aaa", so_v); end
        total++; if (busy_v !== 12'hFFF) begin bad++; $display("FAIL clamp_busy got=%h exp=fff", busy_v); end
        // STOP together with START, landing while a pulse is active.
        bus_write(C_BASE + 16'd1, 8'h03);
        total++; if (START_OUT !== 1'b0) begin bad++; $display("FAIL stop_start_out got=%b exp=0", START_OUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b exp=0", BUSY); end
        @(negedge BUS_CLK);
        total++; if (START_OUT !== 1'b0) begin bad++; $display("FAIL stop_hold got=%b exp=0", START_OUT); end
        bus_read(C_BASE + 16'd1, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL stop_status got=%h exp=01", d); end
    endtask

    task automatic test_shadow_invert;
        logic [7:0]  d;
        logic [19:0] so_v, busy_v;
        logic [10:0] so2_v;
        bus_write(C_BASE + 16'd5, 8'd2);
        bus_write(C_BASE + 16'd7, 8'd6);
        bus_write(C_BASE + 16'd9, 8'd3);
        bus_write(C_BASE + 16'd1, 8'h01);
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    if (k > 0) @(negedge BUS_CLK);
                    so_v[k] = START_OUT; busy_v[k] = BUSY;
                end
            end
            begin
                repeat (2) @(negedge BUS_CLK);
                bus_write(C_BASE + 16'd5, 8'd8);
                bus_write(C_BASE + 16'd1, 8'h01);
            end
        join
        total++; if (so_v !== 20'h06186) begin bad++; $display("FAIL shadow_start_out got=%h exp=06186", so_v); end
        total++; if (busy_v !== 20'h3FFFF) begin bad++; $display("FAIL shadow_busy got=%h exp=3ffff", busy_v); end
        bus_read(C_BASE + 16'd5, d);
        total++; if (d !== 8'h08) begin bad++; $display("FAIL shadow_width_reg got=%h exp=08", d); end
        bus_write(C_BASE + 16'd1, 8'h01);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) @(negedge BUS_CLK);
            so2_v[k] = START_OUT;
        end
        total++; if (so2_v !== 11'h5FE) begin bad++; $display("FAIL wide_pulse got=%h exp=5fe", so2_v); end
        bus_write(C_BASE + 16'd1, 8'h02);
        bus_write(C_BASE + 16'd2, 8'h02);
        @(negedge BUS_CLK);
        total++; if (START_OUT !== 1'b1) begin bad++; $display("FAIL invert_idle got=%b exp=1", START_OUT); end
        bus_read(C_BASE + 16'd2, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL invert_conf got=%h exp=02", d); end
    endtask

    task automatic test_soft_reset;
        logic [7:0] d;
        bus_write(C_BASE + 16'd0, 8'h5A);
        bus_write(C_BASE + 16'd5, 8'd50);
        bus_write(C_BASE + 16'd1, 8'h01);
        repeat (3) @(negedge BUS_CLK);
        total++; if (START_OUT !== 1'b1) begin bad++; $display("FAIL soft_pre_pulse got=%b exp=1", START_OUT); end
        bus_write(C_BASE + 16'd0, 8'h00);
        total++; if (START_OUT !== 1'b0) begin bad++; $display("FAIL soft_rst_start_out got=%b exp=0", START_OUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL soft_rst_busy got=%b exp=0", BUSY); end
        bus_read(C_BASE + 16'd5, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL soft_rst_width got=%h exp=01", d); end
    endtask

`ifdef SEQ_START_GEN_EXT_TRIG_EN
    task automatic test_ext_trigger;
        logic [7:0] d, so_v, busy_v;
        logic [3:0] fb_v;
        bus_write(C_BASE + 16'd3, 8'd2);
        bus_write(C_BASE + 16'd2, 8'h01);
        EXT_TRIGGER = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge BUS_CLK);
            so_v[k] = START_OUT; busy_v[k] = BUSY;
        end
        total++; if (so_v !== 8'h40) begin bad++; $display("FAIL ext_start_out got=%h exp=40", so_v); end
        total++; if (busy_v !== 8'h78) begin bad++; $display("FAIL ext_busy got=%h exp=78", busy_v); end
        EXT_TRIGGER = 1'b0;
        bus_write(C_BASE + 16'd3, 8'd0);
        bus_write(C_BASE + 16'd9, 8'd0);
        bus_write(C_BASE + 16'd1, 8'h01);
        repeat (10) begin
            @(negedge BUS_CLK) EXT_TRIGGER = 1'b1;
            @(negedge BUS_CLK) EXT_TRIGGER = 1'b0;
        end
        repeat (5) @(negedge BUS_CLK);
        bus_read(C_BASE + 16'd11, d);
        total++; if (d !== 8'd10) begin bad++; $display("FAIL missed_count got=%0d exp=10", d); end
        repeat (300) begin
            @(negedge BUS_CLK) EXT_TRIGGER = 1'b1;
            @(negedge BUS_CLK) EXT_TRIGGER = 1'b0;
        end
        repeat (5) @(negedge BUS_CLK);
        bus_read(C_BASE + 16'd11, d);
        total++; if (d !== 8'd255) begin bad++; $display("FAIL missed_saturate got=%0d exp=255", d); end
        bus_write(C_BASE + 16'd1, 8'h02);
        // Falling-edge mode: a rising edge must not launch.
        bus_write(C_BASE + 16'd2, 8'h05);
        EXT_TRIGGER = 1'b1;
        repeat (6) @(negedge BUS_CLK);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL falling_ignores_rise got=%b exp=0", BUSY); end
        EXT_TRIGGER = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge BUS_CLK);
            fb_v[k] = BUSY;
        end
        total++; if (fb_v !== 4'b1000) begin bad++; $display("FAIL falling_latency got=%b exp=1000", fb_v); end
        bus_write(C_BASE + 16'd0, 8'h00);
        bus_read(C_BASE + 16'd11, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL soft_rst_missed got=%h exp=00", d); end
    endtask
`else
    task automatic test_ext_trigger;
        logic [7:0] d;
        bus_write(C_BASE + 16'd2, 8'h07);
        bus_read(C_BASE + 16'd2, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL conf_masked got=%h exp=02", d); end
        repeat (4) begin
            @(negedge BUS_CLK) EXT_TRIGGER = 1'b1;
            @(negedge BUS_CLK) EXT_TRIGGER = 1'b0;
        end
        repeat (4) @(negedge BUS_CLK);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL ext_ignored got=%b exp=0", BUSY); end
        bus_read(C_BASE + 16'd11, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL missed_zero got=%h exp=00", d); end
        bus_write(C_BASE + 16'd0, 8'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_async_reset();
        test_delay_single();
        test_repeat();
        test_continuous_stop();
        test_shadow_invert();
        test_soft_reset();
        test_ext_trigger();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
